// File: rtl/klp32_pkg.sv
// ---------------------------------------------------------------------------
// klp32_pkg
// Shared definitions for the klp32 core's data-memory path.
//   ls_mode_t      : 3-bit LoadStoreMode, encoded like the RISC-V funct3 field
//                    so control, arbiter and data memory agree on one type.
//   MEM_PORT_CORE  : arbiter port index of the core load/store path.
//   MEM_PORT_DBG   : arbiter port index of the debug/loader requester.
// ---------------------------------------------------------------------------
package klp32_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_mode_t;

    localparam logic MEM_PORT_CORE = 1'b0;
    localparam logic MEM_PORT_DBG  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin pick, purely combinational.
//   req[1:0] : request per port
//   last     : port granted most recently
//   pick     : selected port index (meaningful only when valid)
//   valid    : at least one port is requesting
// On a tie the port that was not granted last wins; otherwise the single
// requester is picked.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the core load/store path
// (port 0) and a debug/loader requester (port 1).
//   clk, reset       : rising-edge clock, synchronous active-low reset
//   req/lock/we[1:0] : per-port request, grant lock, write enable
//   addrN/wdataN/modeN: per-port command
//   gnt[1:0]         : combinational grant, one-hot or zero
//   rvalid[1:0]      : registered read-data strobe, one cycle after a read grant
//   rdata            : registered read data shared by both ports
//   core_stall       : port 0 requesting but not granted
//   mem_*            : command to the memory, mem_rdata is its combinational
//                      read data
// A locked port keeps the grant for up to MAX_BURST consecutive cycles while
// the other port waits; with the other port idle the lock is kept forever.
// ---------------------------------------------------------------------------
module dmem_arbiter
    import klp32_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  ls_mode_t          mode0,
    input  ls_mode_t          mode1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              core_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output ls_mode_t          mem_mode,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic             last_reg;
    logic             owner_valid_reg;
    logic             owner_reg;
    logic [CNT_W-1:0] burst_cnt_reg;
    logic [CNT_W-1:0] burst_cnt_next;

    logic rr_pick;
    logic rr_valid;
    logic hold;
    logic g;
    logic any_grant;
    logic lock_now;
    logic [1:0] read_gnt;

    rr_arb2 u_rr (
        .req   (req),
        .last  (last_reg),
        .pick  (rr_pick),
        .valid (rr_valid)
    );

    // The lock holder keeps the port unless it has used up its burst and
    // the other side is actually waiting.
    assign hold = owner_valid_reg & req[owner_reg]
                & ((burst_cnt_reg < BURST_MAX) | ~req[~owner_reg]);
    assign g         = hold ? owner_reg : rr_pick;
    // While reset is asserted (low) nothing is granted.
    assign any_grant = reset & (hold | rr_valid);
    assign lock_now  = any_grant & lock[g];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt[gi]      = any_grant & (g == 1'(gi));
        assign read_gnt[gi] = gnt[gi] & ~we[gi];
    end

    assign core_stall = req[MEM_PORT_CORE] & ~gnt[MEM_PORT_CORE];

    // With no grant the command falls back to port 0 with mem_we low.
    assign mem_we    = |(we & gnt);
    assign mem_addr  = gnt[MEM_PORT_DBG] ? addr1  : addr0;
    assign mem_wdata = gnt[MEM_PORT_DBG] ? wdata1 : wdata0;
    assign mem_mode  = gnt[MEM_PORT_DBG] ? mode1  : mode0;

    // A hold continues the current burst; any other locked grant starts one.
    always_comb begin
        burst_cnt_next = '0;
        if (lock_now) begin
            if (hold) begin
                burst_cnt_next = (burst_cnt_reg == BURST_MAX) ? burst_cnt_reg
                                                              : burst_cnt_reg + 1'b1;
            end else begin
                burst_cnt_next = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_reg        <= 1'b1;
            owner_valid_reg <= 1'b0;
            owner_reg       <= 1'b0;
            burst_cnt_reg   <= '0;
            rvalid          <= 2'b00;
            rdata           <= '0;
        end else begin
            if (any_grant) begin
                last_reg <= g;
            end
            owner_valid_reg <= lock_now;
            owner_reg       <= g;
            burst_cnt_reg   <= burst_cnt_next;
            rvalid          <= read_gnt;
            if (|read_gnt) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed vectors for dmem_arbiter with hand-computed expectations.
// Inputs change 1 ns after the rising edge; combinational outputs are
// sampled 2 ns later, registered outputs 1 ns after the next edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import klp32_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req, lock, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    ls_mode_t    mode0, mode1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        core_stall, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    ls_mode_t    mem_mode;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .mode0      (mode0),
        .mode1      (mode1),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .core_stall (core_stall),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mode   (mem_mode),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h t=%0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; req = 2'b00; lock = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mode0 = LS_W; mode1 = LS_W; mem_rdata = '0;
        tick();

        // Requests during reset are ignored
        req = 2'b11; we = 2'b11;
        #2;
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_mem_we", 32'(mem_we), 32'h0);
        tick();
        check_val("rst_rvalid", 32'(rvalid), 32'h0);
        check_val("rst_rdata", rdata, 32'h0);

        // Single port-0 read
        reset = 1'b1; req = 2'b01; we = 2'b00; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
        #2;
        check_val("rd0_gnt", 32'(gnt), 32'h1);
        check_val("rd0_addr", mem_addr, 32'h10);
        check_val("rd0_stall", 32'(core_stall), 32'h0);
        check_val("rd0_mem_we", 32'(mem_we), 32'h0);
        tick();
        check_val("rd0_rvalid", 32'(rvalid), 32'h1);
        check_val("rd0_rdata", rdata, 32'hDEADBEEF);

        // Single port-1 read, leaves last=1
        req = 2'b10; addr1 = 32'h44; mem_rdata = 32'hCAFEF00D;
        #2;
        check_val("rd1_gnt", 32'(gnt), 32'h2);
        check_val("rd1_addr", mem_addr, 32'h44);
        check_val("rd1_stall", 32'(core_stall), 32'h0);
        tick();
        check_val("rd1_rvalid", 32'(rvalid), 32'h2);
        check_val("rd1_rdata", rdata, 32'hCAFEF00D);

        // Unlocked tie alternates 0,1,0,1 with back-to-back rvalid
        for (int i = 0; i < 4; i++) begin
            req = 2'b11; mem_rdata = 32'h100 + 32'(i);
            #2;
            check_val("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            check_val("rr_stall", 32'(core_stall), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            check_val("rr_rvalid", 32'(rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
            check_val("rr_rdata", rdata, 32'h100 + 32'(i));
        end

        // Port-0 store word
        req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h1234; mode0 = LS_W;
        #2;
        check_val("wr_gnt", 32'(gnt), 32'h1);
        check_val("wr_mem_we", 32'(mem_we), 32'h1);
        check_val("wr_addr", mem_addr, 32'h20);
        check_val("wr_wdata", mem_wdata, 32'h1234);
        check_val("wr_mode", 32'(mem_mode), 32'(LS_W));
        tick();
        check_val("wr_rvalid", 32'(rvalid), 32'h0);
        check_val("wr_rdata_hold", rdata, 32'h103);

        // Port 1 locked write burst vs continuous port-0 reads (last=0)
        addr0 = 32'h30; wdata1 = 32'h5555; mode1 = LS_H;
        for (int i = 0; i < 5; i++) begin
            req = 2'b11; lock = 2'b10; we = 2'b10;
            addr1 = 32'h80 + 32'(i); mem_rdata = 32'h200 + 32'(i);
            #2;
            check_val("bur_gnt", 32'(gnt), (i < 4) ? 32'h2 : 32'h1);
            check_val("bur_mem_we", 32'(mem_we), (i < 4) ? 32'h1 : 32'h0);
            check_val("bur_addr", mem_addr, (i < 4) ? 32'h80 + 32'(i) : 32'h30);
            check_val("bur_mode", 32'(mem_mode), (i < 4) ? 32'(LS_H) : 32'(LS_W));
            tick();
            check_val("bur_rvalid", 32'(rvalid), (i < 4) ? 32'h0 : 32'h1);
        end
        check_val("bur_rdata", rdata, 32'h204);

        // Port 1 locked with port 0 idle: kept for 10 cycles, counter saturates
        for (int i = 0; i < 10; i++) begin
            req = 2'b10; lock = 2'b10; we = 2'b10;
            #2;
            check_val("idle_gnt", 32'(gnt), 32'h2);
            tick();
            check_val("idle_burst_cnt", 32'(dut.burst_cnt_reg), (i < 3) ? 32'(i + 1) : 32'h4);
        end
        // Saturated burst yields as soon as port 0 asks
        req = 2'b11;
        #2;
        check_val("sat_switch_gnt", 32'(gnt), 32'h1);
        check_val("sat_switch_stall", 32'(core_stall), 32'h0);
        tick();

        // Dropping req while locked releases in the same cycle
        req = 2'b10; lock = 2'b10; we = 2'b00;
        #2;
        check_val("drop_setup_gnt", 32'(gnt), 32'h2);
        tick();
        req = 2'b01; lock = 2'b00;
        #2;
        check_val("drop_release_gnt", 32'(gnt), 32'h1);
        tick();

        // Reset during a locked read burst
        req = 2'b10; lock = 2'b10; we = 2'b00;
        tick();
        tick();
        reset = 1'b0; we = 2'b10;
        #2;
        check_val("rstb_gnt", 32'(gnt), 32'h0);
        check_val("rstb_mem_we", 32'(mem_we), 32'h0);
        we = 2'b00;
        tick();
        check_val("rstb_rvalid", 32'(rvalid), 32'h0);
        reset = 1'b1; req = 2'b11; lock = 2'b00;
        #2;
        check_val("post_rst_gnt", 32'(gnt), 32'h1);
        check_val("post_rst_rvalid", 32'(rvalid), 32'h0);
        tick();
        check_val("post_rst_rvalid2", 32'(rvalid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data-memory port between the core's load/store path (port 0) and a debug/loader requester (port 1). It sits between the core's ALU-address/store-data path and `data_memory32`. It grants one requester per cycle using a round-robin pointer with optional burst locking, drives the memory port, and returns registered read data with a one-cycle valid strobe.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum consecutive locked grants while the other port waits (≥1)

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-low reset
- `req[1:0]` in 2: request per port
- `lock[1:0]` in 2: holds the grant on the next cycle; valid only together with `req`
- `we[1:0]` in 2: per-port write enable
- `addr0`, `addr1` in ADDR_W: per-port address
- `wdata0`, `wdata1` in DATA_W: per-port store data
- `mode0`, `mode1` in 3: per-port LoadStoreMode
- `gnt[1:0]` out 2: combinational grant, one-hot or zero
- `rvalid[1:0]` out 2: read data valid, registered
- `rdata` out DATA_W: registered read data, shared by both ports
- `core_stall` out 1: `req[0] & ~gnt[0]`
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_mode` out 3: memory command
- `mem_rdata` in DATA_W: combinational read data from memory

## Operation
- State: `last` (1 bit, port granted most recently), `owner_valid`, `owner`, `burst_cnt` (width clog2(MAX_BURST)+1).
- Arbitration each cycle, combinational:
  - If `owner_valid`, `req[owner]` is high and (`burst_cnt < MAX_BURST` or `req[~owner]` is low), grant `owner`. This is the lock hold.
  - Otherwise, if both ports request, grant `~last`.
  - Otherwise, grant the single requester.
  - Otherwise, no grant.
- Memory mux: `mem_addr`, `mem_wdata` and `mem_mode` come from the granted port. With no grant they come from port 0 and `mem_we` is 0. `mem_we = we[g] & gnt[g]`.
- On a granted read (`we=0`), `mem_rdata` is captured into `rdata` and `rvalid[g]` goes to 1 for exactly the next cycle. Granted writes produce no `rvalid`.
- Registers updated at the clock edge:
  - `last <= g` when any grant is given.
  - `owner_valid <= gnt[g] & lock[g]` and `owner <= g`.
  - `burst_cnt`: 1 on a fresh lock; +1 while holding; saturates at MAX_BURST; 0 when unlocked.
- A lock held past MAX_BURST with the other port idle continues indefinitely. The forced switch happens only when the other port is requesting.
- A lock dropped mid-burst, or `req` dropped while locked, releases immediately. Normal round-robin applies in that same cycle.

## Timing
- Grant latency 0 cycles: `gnt` and `mem_*` follow `req` combinationally. A write commits at the edge that ends the grant cycle.
- Read latency 1 cycle: `rvalid`/`rdata` are valid the cycle after the grant. Back-to-back reads give an `rvalid` every cycle.
- Reset values (`reset=0` at an edge): `last=1`, so port 0 wins the first tie. `owner_valid=0`, `burst_cnt=0`, `rvalid=0`, `rdata=0`.
- During reset `gnt` is forced to 0 and `mem_we=0` regardless of `req`.
- Reset mid-burst discards the lock. A read granted in the reset cycle produces no `rvalid`.
- Simultaneous requests with no lock alternate every cycle: 0,1,0,1…

## Structure
- Shared package `klp32_pkg`:
  - `ls_mode_t` (3-bit LoadStoreMode enum, shared with the data memory and control).
  - `MEM_PORT_CORE=0` and `MEM_PORT_DBG=1` constants.
- One natural sub-module: `rr_arb2` (two-input round-robin pick from `req` and `last`). Lock/burst logic and the datapath mux stay in the top.

## Test plan
- Reset, then `req=2'b01`, read `addr0=0x10`, `mem_rdata=0xDEADBEEF` → `gnt=01` same cycle; next cycle `rvalid=01`, `rdata=0xDEADBEEF`.
- `req=2'b11` for 4 cycles, no lock → grants 01,10,01,10; `core_stall` high on cycles 2 and 4.
- Port 1 locks a write burst with `MAX_BURST=4` while port 0 requests continuously → port 1 granted 4 cycles, port 0 on cycle 5; `mem_we=1` only on port-1 cycles.
- Port 1 locked with port 0 idle for 10 cycles → port 1 granted all 10; `burst_cnt` saturates at 4.
- Port 0 write `addr0=0x20`, `wdata0=0x1234`, mode SW → `mem_we=1`, `mem_addr=0x20`, `mem_wdata=0x1234`; no `rvalid` the following cycle.
- Assert reset during a locked burst with a read granted → `gnt=0`, `mem_we=0`; after release, with `req=11`, port 0 is granted first and no `rvalid` is left over from the aborted read.
